des_decrypt_iter: RTL and testbench
===================================

// Module: des_decrypt_iter
// PURPOSE
//  Iterative DES decryption core: accepts a 64-bit ciphertext and 64-bit key, runs the 16 Feistel
//  rounds with the key schedule in reverse order (K16..K1), returns the plaintext. Uses Sbox1..Sbox8
//  unchanged in each round datapath. Sits opposite the pipelined encryptor as its receive-side engine.
// PARAMETERS
//  RPC  1  rounds per clock; legal 1,2,4,8,16 (unrolled round copies); others -> elaboration error
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   ct/key valid
//  in_ready   out  1   core can accept (state IDLE)
//  ct         in   64  ciphertext, [0:63], bit 0 = DES bit 1
//  key        in   64  key, [0:63]; parity bits 7,15,..,63 ignored
//  out_valid  out  1   pt valid (state DONE)
//  out_ready  in   1   consumer accepts pt
//  pt         out  64  plaintext, [0:63]
//  busy       out  1   high in RUN or DONE
// BEHAVIOUR
//  - Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  - Reset (async assert, sync release): state=IDLE, round counter=0, L/R/C/D regs=0, pt=0,
//    out_valid=0, busy=0; in_ready=1. Reset in any state aborts the operation, no output produced.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&in_ready at edge E0: L||R <= IP(ct), C||D <= PC-1(key), cnt<=0 -> RUN.
//    RUN: each edge performs RPC rounds: L'=R, R'=L ^ f(R,Kr). cnt += RPC. When cnt reaches 16 -> DONE.
//    DONE: out_valid=1, pt = FP(R16||L16) (registered, stable). out_valid&out_ready -> IDLE same edge.
//  - Latency: out_valid rises after edge E0+16/RPC (RPC=1: 16 edges after accept). Throughput: one
//    block per 16/RPC+2 cycles minimum; no overlap of blocks.
//  - Reverse key schedule: round 1 uses PC-2(C0,D0) (=K16). Before rounds 2..16 rotate C,D RIGHT by
//    1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. 28-bit rotations wrap within C and D independently.
//  - f(R,K): E-expand to 48, XOR K, 6-bit groups 0..7 -> Sbox1..Sbox8 (group 0 = bits 0:5), concat 32, P.
//  - in_valid in RUN/DONE ignored (in_ready=0); ct/key sampled only at accept, later changes ignored.
//  - out_ready held low: pt/out_valid hold indefinitely. out_ready in IDLE/RUN: no effect.
//  - busy = (state!=IDLE).
// CONFIGURATION
//  DES_ENC_MODE_EN defined: extra input `enc` (1 bit), sampled at accept; enc=1 uses forward schedule
//   (round 1 LEFT-rotate by 1 then PC-2; shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 left) giving encryption
//   with identical timing; enc=0 is decryption as above.
//  Undefined: no `enc` port; decryption only.
// TESTING
//  1. key=133457799BBCDFF1, ct=85E813540F0AB405 -> pt=0123456789ABCDEF; RPC=1 out_valid 16 edges after accept.
//  2. key=0101010101010101 (parity-only), ct=8CA64DE9C1B123A7 -> pt=0000000000000000 (parity ignored).
//  3. key=0E329232EA6D0D73, ct=0000000000000000 -> pt=8787878787878787; hold out_ready=0 for 5 cycles
//     -> pt/out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
//  4. Second in_valid with different ct during RUN -> ignored; first result unchanged; back-to-back
//     after DONE handshake accepted, correct result.
//  5. rst_n low at round 8 -> out_valid=0, pt=0, in_ready=1 immediately; next block decrypts correctly.
//  6. DES_ENC_MODE_EN, enc=1, key=133457799BBCDFF1, ct=0123456789ABCDEF -> pt=85E813540F0AB405;
//     repeat 1-2 for RPC=2,4,16 with latency 8,4,1 edges.

Source files
------------

// File: rtl/des_decrypt_iter_if.sv
// Handshake bundle for des_decrypt_iter: ciphertext/key request channel,
// plaintext response channel and a busy flag.
// Optional DES_ENC_MODE_EN adds the 'enc' request bit (forward key schedule).
interface des_decrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] ct;
    logic [0:63] key;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] pt;
    logic        busy;
`ifdef DES_ENC_MODE_EN
    logic        enc;
`endif

    modport master (
`ifdef DES_ENC_MODE_EN
        output enc,
`endif
        output in_valid, ct, key, out_ready,
        input  in_ready, out_valid, pt, busy
    );

    modport slave (
`ifdef DES_ENC_MODE_EN
        input  enc,
`endif
        input  in_valid, ct, key, out_ready,
        output in_ready, out_valid, pt, busy
    );
endinterface

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core. RPC Feistel rounds per clock (1,2,4,8,16),
// key schedule walked backwards from K16 to K1 by rotating C/D right.
// Bit vectors use DES numbering: index 0 is DES bit 1 (the MSB).
// Optional macro DES_ENC_MODE_EN: adds an 'enc' request bit selecting the
// forward (encryption) key schedule with identical timing.
module des_decrypt_iter #(
    parameter int RPC = 1
) (
    input logic               clk,
    input logic               rst_n,
    des_decrypt_iter_if.slave bus
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_rpc_check
        $error("des_decrypt_iter: RPC must be one of 1, 2, 4, 8, 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Permutation tables hold 1-based DES bit numbers; FP is the inverse of IP.
    localparam logic [0:63][6:0] IP_T = {
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,  7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [0:31][5:0] P_T = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17, 6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,  6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    // PC-1 skips the parity bits 8,16,..,64, so they never reach the schedule.
    localparam logic [0:55][5:0] PC1_T = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [0:47][5:0] PC2_T = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // S-boxes: one 64-bit word per row, column 0 in the top nibble.
    localparam logic [0:7][0:3][63:0] SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [0:63] perm_ip(input logic [0:63] x);
        logic [0:63] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) y[i] = x[6'(IP_T[i] - 7'd1)];
        return y;
    endfunction

    function automatic logic [0:63] perm_fp(input logic [0:63] x);
        logic [0:63] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) y[6'(IP_T[i] - 7'd1)] = x[i];
        return y;
    endfunction

    function automatic logic [0:55] perm_pc1(input logic [0:63] k);
        logic [0:55] y;
        y = 56'd0;
        for (int i = 0; i < 56; i++) y[i] = k[PC1_T[i] - 6'd1];
        return y;
    endfunction

    function automatic logic [0:47] perm_pc2(input logic [0:55] cd);
        logic [0:47] y;
        y = 48'd0;
        for (int i = 0; i < 48; i++) y[i] = cd[PC2_T[i] - 6'd1];
        return y;
    endfunction

    // Rotation applied before round 'rnd' (0-based). Decryption: none before
    // round 0, then right by 1 at rounds 1, 8, 15 and by 2 elsewhere.
    // Encryption: left by 1 at rounds 0, 1, 8, 15 and by 2 elsewhere.
    function automatic logic [1:0] key_shift(input logic [4:0] rnd, input logic enc);
        logic single;
        single = (rnd == 5'd1) || (rnd == 5'd8) || (rnd == 5'd15);
        if (enc) begin
            return (single || (rnd == 5'd0)) ? 2'd1 : 2'd2;
        end else if (rnd == 5'd0) begin
            return 2'd0;
        end else begin
            return single ? 2'd1 : 2'd2;
        end
    endfunction

    function automatic logic [0:27] rot28(input logic [0:27] c, input logic [1:0] n, input logic left);
        logic [0:27] y;
        if (left) begin
            case (n)
                2'd1:    y = {c[1:27], c[0]};
                2'd2:    y = {c[2:27], c[0:1]};
                default: y = c;
            endcase
        end else begin
            case (n)
                2'd1:    y = {c[27], c[0:26]};
                2'd2:    y = {c[26:27], c[0:25]};
                default: y = c;
            endcase
        end
        return y;
    endfunction

    function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
        logic [0:47] x;
        logic [0:31] s;
        logic [0:31] y;
        logic [0:5]  grp;
        logic [1:0]  row;
        logic [3:0]  col;
        logic [63:0] word;
        x = 48'd0;
        s = 32'd0;
        y = 32'd0;
        // E expansion: group g takes R bits 4g-1 .. 4g+4 (wrapping).
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 6; j++) begin
                x[g*6 + j] = r[5'((4*g + j + 31) % 32)];
            end
        end
        x = x ^ k;
        for (int g = 0; g < 8; g++) begin
            grp  = x[g*6 +: 6];
            row  = {grp[0], grp[5]};
            col  = grp[1:4];
            word = SBOX[g][row];
            s[g*4 +: 4] = 4'(word >> (6'd60 - {col, 2'b00}));
        end
        for (int i = 0; i < 32; i++) y[i] = s[5'(P_T[i] - 6'd1)];
        return y;
    endfunction

    state_t      state_r, state_nx;
    logic [4:0]  cnt_r, cnt_nx;
    logic [0:31] l_r, r_r, l_nx, r_nx;
    logic [0:27] c_r, d_r, c_nx, d_nx;
    logic [0:63] pt_r, pt_nx;
    logic        in_ready_r, out_valid_r, busy_r;
    logic        mode_enc_s;

    logic [0:31] l_rnd_s, r_rnd_s, f_s;
    logic [0:27] c_rnd_s, d_rnd_s;
    logic [4:0]  rnd_s;
    logic [1:0]  sh_s;
    logic [0:47] rk_s;

`ifdef DES_ENC_MODE_EN
    logic        enc_r, enc_nx;
    assign mode_enc_s = enc_r;
`else
    assign mode_enc_s = 1'b0;
`endif

    // RPC unrolled rounds starting at round index cnt_r
    always_comb begin
        l_rnd_s = l_r;
        r_rnd_s = r_r;
        c_rnd_s = c_r;
        d_rnd_s = d_r;
        rnd_s   = cnt_r;
        sh_s    = 2'd0;
        rk_s    = 48'd0;
        f_s     = 32'd0;
        for (int k = 0; k < RPC; k++) begin
            rnd_s   = cnt_r + 5'(k);
            sh_s    = key_shift(rnd_s, mode_enc_s);
            c_rnd_s = rot28(c_rnd_s, sh_s, mode_enc_s);
            d_rnd_s = rot28(d_rnd_s, sh_s, mode_enc_s);
            rk_s    = perm_pc2({c_rnd_s, d_rnd_s});
            f_s     = l_rnd_s ^ feistel(r_rnd_s, rk_s);
            l_rnd_s = r_rnd_s;
            r_rnd_s = f_s;
        end
    end

    // Next-state and datapath load/update selection
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        l_nx     = l_r;
        r_nx     = r_r;
        c_nx     = c_r;
        d_nx     = d_r;
        pt_nx    = pt_r;
`ifdef DES_ENC_MODE_EN
        enc_nx   = enc_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nx     = ST_RUN;
                    {l_nx, r_nx} = perm_ip(bus.ct);
                    {c_nx, d_nx} = perm_pc1(bus.key);
                    cnt_nx       = 5'd0;
`ifdef DES_ENC_MODE_EN
                    enc_nx       = bus.enc;
`endif
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                l_nx   = l_rnd_s;
                r_nx   = r_rnd_s;
                c_nx   = c_rnd_s;
                d_nx   = d_rnd_s;
                cnt_nx = cnt_r + 5'(RPC);
                if (cnt_nx == 5'd16) begin
                    state_nx = ST_DONE;
                    // Final swap: output is FP(R16 || L16).
                    pt_nx    = perm_fp({r_rnd_s, l_rnd_s});
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            l_r         <= 32'd0;
            r_r         <= 32'd0;
            c_r         <= 28'd0;
            d_r         <= 28'd0;
            pt_r        <= 64'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef DES_ENC_MODE_EN
            enc_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            l_r         <= l_nx;
            r_r         <= r_nx;
            c_r         <= c_nx;
            d_r         <= d_nx;
            pt_r        <= pt_nx;
            in_ready_r  <= (state_nx == ST_IDLE);
            out_valid_r <= (state_nx == ST_DONE);
            busy_r      <= (state_nx != ST_IDLE);
`ifdef DES_ENC_MODE_EN
            enc_r       <= enc_nx;
`endif
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.pt        = pt_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed testbench for des_decrypt_iter: RPC=1 main instance plus RPC=2,4,16
// instances for latency/result checks of the unrolled datapath.
module tb_des_decrypt_iter;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [0:63] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [0:63] CT1  = 64'h85E813540F0AB405;
    localparam logic [0:63] PT1  = 64'h0123456789ABCDEF;
    localparam logic [0:63] KEY2 = 64'h0101010101010101;
    localparam logic [0:63] CT2  = 64'h8CA64DE9C1B123A7;
    localparam logic [0:63] PT2  = 64'h0000000000000000;
    localparam logic [0:63] KEY3 = 64'h0E329232EA6D0D73;
    localparam logic [0:63] CT3  = 64'h0000000000000000;
    localparam logic [0:63] PT3  = 64'h8787878787878787;

    des_decrypt_iter_if bus   ();
    des_decrypt_iter_if bus2  ();
    des_decrypt_iter_if bus4  ();
    des_decrypt_iter_if bus16 ();

    des_decrypt_iter #(.RPC(1))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    des_decrypt_iter #(.RPC(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    des_decrypt_iter #(.RPC(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    des_decrypt_iter #(.RPC(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input logic [0:63] c, input logic [0:63] k);
        bus.ct       = c;
        bus.key      = k;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done1(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;  bus.ct = 64'd0;  bus.key = 64'd0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.ct = 64'd0; bus2.key = 64'd0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.ct = 64'd0; bus4.key = 64'd0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.ct = 64'd0; bus16.key = 64'd0;
`ifdef DES_ENC_MODE_EN
        bus.enc = 1'b0; bus2.enc = 1'b0; bus4.enc = 1'b0; bus16.enc = 1'b0;
`endif
        #2;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.pt !== 64'd0) begin failures++; $display("FAIL reset_pt got=%h exp=0", bus.pt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decrypt_basic();
        int cyc;
        start1(CT1, KEY1);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_run got=%b exp=0", bus.in_ready); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_run got=%b exp=1", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_valid_run got=%b exp=0", bus.out_valid); end
        wait_done1(cyc);
        checks++; if (cyc != 16) begin failures++; $display("FAIL basic_latency got=%0d exp=16", cyc); end
        checks++; if (bus.pt !== PT1) begin failures++; $display("FAIL basic_pt got=%h exp=%h", bus.pt, PT1); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_back_idle got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_parity_key();
        logic [0:63] keys [2];
        int cyc;
        keys[0] = KEY2;
        keys[1] = 64'h0000000000000000;
        for (int i = 0; i < 2; i++) begin
            start1(CT2, keys[i]);
            wait_done1(cyc);
            checks++; if (bus.pt !== PT2) begin failures++; $display("FAIL parity_pt key=%h got=%h exp=%h", keys[i], bus.pt, PT2); end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_hold_out_ready();
        int cyc;
        start1(CT3, KEY3);
        wait_done1(cyc);
        bus.in_valid = 1'b1;
        bus.ct = CT1;
        bus.key = KEY1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.pt !== PT3) begin
                failures++; $display("FAIL hold_out cyc=%0d got valid=%b pt=%h exp 1/%h", i, bus.out_valid, bus.pt, PT3);
            end
            checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++; $display("FAIL hold_flags cyc=%0d got in_ready=%b busy=%b exp 0/1", i, bus.in_ready, bus.busy);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL hold_release got valid=%b in_ready=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start1(CT1, KEY1);
        repeat (8) tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.pt !== 64'd0) begin
            failures++; $display("FAIL midrst_out got valid=%b pt=%h exp 0/0", bus.out_valid, bus.pt);
        end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL midrst_flags got in_ready=%b busy=%b exp 1/0", bus.in_ready, bus.busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start1(CT3, KEY3);
        wait_done1(cyc);
        checks++; if (cyc != 16 || bus.pt !== PT3) begin
            failures++; $display("FAIL midrst_next got lat=%0d pt=%h exp 16/%h", cyc, bus.pt, PT3);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        start1(CT1, KEY1);
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.ct = CT2;
        bus.key = KEY2;
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_run got=%b exp=0", bus.in_ready); end
        repeat (3) tick();
        bus.in_valid = 1'b0;
        wait_done1(cyc);
        checks++; if (bus.pt !== PT1) begin failures++; $display("FAIL b2b_first_pt got=%h exp=%h", bus.pt, PT1); end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_handshake got in_ready=%b valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", bus.busy); end
        wait_done1(cyc);
        checks++; if (cyc != 16 || bus.pt !== PT2) begin
            failures++; $display("FAIL b2b_second got lat=%0d pt=%h exp 16/%h", cyc, bus.pt, PT2);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rpc_variants();
        int cyc;
        // RPC=2
        bus2.ct = CT2; bus2.key = KEY2; bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        cyc = 0;
        while (bus2.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
        checks++; if (cyc != 8 || bus2.pt !== PT2) begin
            failures++; $display("FAIL rpc2 got lat=%0d pt=%h exp 8/%h", cyc, bus2.pt, PT2);
        end
        bus2.out_ready = 1'b1; tick(); bus2.out_ready = 1'b0;
        // RPC=4
        bus4.ct = CT1; bus4.key = KEY1; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        cyc = 0;
        while (bus4.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
        checks++; if (cyc != 4 || bus4.pt !== PT1) begin
            failures++; $display("FAIL rpc4 got lat=%0d pt=%h exp 4/%h", cyc, bus4.pt, PT1);
        end
        bus4.out_ready = 1'b1; tick(); bus4.out_ready = 1'b0;
        // RPC=16
        bus16.ct = CT3; bus16.key = KEY3; bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        cyc = 0;
        while (bus16.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
        checks++; if (cyc != 1 || bus16.pt !== PT3) begin
            failures++; $display("FAIL rpc16 got lat=%0d pt=%h exp 1/%h", cyc, bus16.pt, PT3);
        end
        bus16.out_ready = 1'b1; tick(); bus16.out_ready = 1'b0;
        checks++; if (bus16.in_ready !== 1'b1) begin failures++; $display("FAIL rpc16_idle got=%b exp=1", bus16.in_ready); end
    endtask

`ifdef DES_ENC_MODE_EN
    task automatic test_enc_mode();
        int cyc;
        bus.enc = 1'b1;
        start1(PT1, KEY1);
        bus.enc = 1'b0;
        wait_done1(cyc);
        checks++; if (cyc != 16 || bus.pt !== CT1) begin
            failures++; $display("FAIL enc_mode got lat=%0d pt=%h exp 16/%h", cyc, bus.pt, CT1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_decrypt_basic();
        test_parity_key();
        test_hold_out_ready();
        test_reset_mid_run();
        test_back_to_back();
        test_rpc_variants();
`ifdef DES_ENC_MODE_EN
        test_enc_mode();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
